chebyshev_eval_ctrl: RTL

CHEBYSHEV_EVAL_CTRL -- requirements
Module: chebyshev_eval_ctrl

---
 rtl/chebyshev_eval_ctrl_if.sv | 33 +++
 rtl/chebyshev_eval_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/chebyshev_eval_ctrl_if.sv
// Handshake and coefficient-ROM bus for chebyshev_eval_ctrl.
// Optional sat_flag signal exists only when CHEBYSHEV_SAT_FLAG_EN is defined.
interface chebyshev_eval_ctrl_if #(
    parameter int WL     = 16,
    parameter int CL     = 16,
    parameter int O_BITS = 16,
    parameter int S      = 4,
    parameter int DEGREE = 2
);
    localparam int ADDR_W = $clog2(S * (DEGREE + 1));

    logic                     in_valid;
    logic                     in_ready;
    logic signed [WL-1:0]     data_in;
    logic [ADDR_W-1:0]        coeff_addr;
    logic signed [CL-1:0]     coeff_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [O_BITS-1:0] data_out;
`ifdef CHEBYSHEV_SAT_FLAG_EN
    logic                     sat_flag;

    modport master (output in_valid, data_in, coeff_data, out_ready,
                    input  in_ready, coeff_addr, out_valid, data_out, sat_flag);
    modport slave  (input  in_valid, data_in, coeff_data, out_ready,
                    output in_ready, coeff_addr, out_valid, data_out, sat_flag);
`else
    modport master (output in_valid, data_in, coeff_data, out_ready,
                    input  in_ready, coeff_addr, out_valid, data_out);
    modport slave  (input  in_valid, data_in, coeff_data, out_ready,
                    output in_ready, coeff_addr, out_valid, data_out);
`endif
endinterface

// File: rtl/chebyshev_eval_ctrl.sv
// Segmented Chebyshev polynomial evaluator using the Clenshaw recurrence, one coefficient per cycle.
// Define CHEBYSHEV_SAT_FLAG_EN to add the sat_flag output (input or output clamping occurred).
module chebyshev_eval_ctrl #(
    parameter int WL      = 16,
    parameter int I_BITS  = 4,
    parameter int CL      = 16,
    parameter int C_FRAC  = 12,
    parameter int S       = 4,
    parameter int DEGREE  = 2,
    parameter int O_BITS  = 16,
    parameter int O_SHIFT = 0
) (
    input logic                  clock,
    input logic                  reset,
    chebyshev_eval_ctrl_if.slave bus
);
    localparam int F        = WL - I_BITS;
    localparam int SEG_BITS = $clog2(S);
    localparam int UW       = F + 1;
    localparam int TW       = UW - SEG_BITS;
    localparam int T_FRAC   = F - SEG_BITS;
    localparam int ACC_W    = CL + $clog2(DEGREE + 1) + 2;
    localparam int PW       = TW + ACC_W;
    localparam int RW       = ACC_W + 1;
    localparam int ADDR_W   = $clog2(S * (DEGREE + 1));
    localparam int KW       = $clog2(DEGREE + 1) + 1;

    localparam logic signed [WL-1:0] U_MAX = WL'(2 ** F - 1);
    localparam logic signed [WL-1:0] U_MIN = WL'(-(2 ** F));
    localparam logic signed [RW-1:0] OMAX  = RW'(2 ** (O_BITS - 1) - 1);
    localparam logic signed [RW-1:0] OMIN  = RW'(-(2 ** (O_BITS - 1)));
    localparam logic signed [RW-1:0] HALF  = (RW'(1) << O_SHIFT) >> 1;
    localparam logic [ADDR_W-1:0]    D1    = ADDR_W'(DEGREE + 1);
    localparam logic [ADDR_W-1:0]    DA    = ADDR_W'(DEGREE);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ITER  = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    generate
        if (S < 2 || (1 << SEG_BITS) != S || DEGREE < 1 || C_FRAC > CL ||
            O_BITS > RW || F <= SEG_BITS) begin : g_bad_cfg
            $error("chebyshev_eval_ctrl: unsupported parameter set");
        end
    endgenerate

    function automatic logic signed [UW-1:0] sat_in_fn(input logic signed [WL-1:0] x);
        if (x > U_MAX)      return U_MAX[UW-1:0];
        else if (x < U_MIN) return U_MIN[UW-1:0];
        else                return x[UW-1:0];
    endfunction

    // Product with t is realigned to the accumulator LSB by a flooring shift.
    function automatic logic signed [ACC_W-1:0] mul_shift(input logic signed [TW-1:0] a,
                                                          input logic signed [ACC_W-1:0] b);
        return ACC_W'((PW'(a) * PW'(b)) >>> T_FRAC);
    endfunction

    function automatic logic signed [RW-1:0] out_round(input logic signed [ACC_W-1:0] y);
        return RW'((RW'(y) + HALF) >>> O_SHIFT);
    endfunction

    function automatic logic signed [O_BITS-1:0] out_sat(input logic signed [RW-1:0] r);
        if (r > OMAX)      return OMAX[O_BITS-1:0];
        else if (r < OMIN) return OMIN[O_BITS-1:0];
        else               return r[O_BITS-1:0];
    endfunction

    logic [1:0]               state;
    logic [KW-1:0]            k;
    logic signed [TW-1:0]     t;
    logic signed [ACC_W-1:0]  b1, b2;

    logic signed [UW-1:0]     u_sat;
    logic [UW-1:0]            ob;
    logic [SEG_BITS-1:0]      seg;
    logic signed [TW-1:0]     t_in;
    logic [ADDR_W-1:0]        base_addr;
    logic signed [ACC_W-1:0]  c_ext, prod, b_next, y_fin;
    logic signed [RW-1:0]     y_rnd;
    logic signed [O_BITS-1:0] y_out;

    // Offset-binary split: top bits pick the segment, the rest is the local abscissa in [-1, 1).
    assign u_sat     = sat_in_fn(bus.data_in);
    assign ob        = {~u_sat[UW-1], u_sat[UW-2:0]};
    assign seg       = ob[UW-1 -: SEG_BITS];
    assign t_in      = {~ob[TW-1], ob[TW-2:0]};
    assign base_addr = ADDR_W'(seg) * D1 + DA;

    assign c_ext  = {{(ACC_W - CL){bus.coeff_data[CL-1]}}, bus.coeff_data};
    assign prod   = mul_shift(t, b1);
    assign b_next = c_ext + (prod <<< 1) - b2;
    assign y_fin  = c_ext + prod - b2;
    assign y_rnd  = out_round(y_fin);
    assign y_out  = out_sat(y_rnd);

    assign bus.in_ready = (state == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            k              <= '0;
            b1             <= '0;
            b2             <= '0;
            bus.coeff_addr <= '0;
            bus.out_valid  <= 1'b0;
            bus.data_out   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state          <= ITER;
                    k              <= KW'(DEGREE);
                    b1             <= '0;
                    b2             <= '0;
                    bus.coeff_addr <= base_addr;
                end
                ITER: begin
                    b2             <= b1;
                    b1             <= b_next;
                    bus.coeff_addr <= bus.coeff_addr - 1'b1;
                    if (k == KW'(1)) state <= FINAL;
                    else             k     <= k - 1'b1;
                end
                FINAL: begin
                    bus.data_out  <= y_out;
                    bus.out_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && bus.in_valid) t <= t_in;
    end

`ifdef CHEBYSHEV_SAT_FLAG_EN
    logic sat_in;

    always_ff @(posedge clock) begin
        if (state == IDLE && bus.in_valid)
            sat_in <= (bus.data_in > U_MAX) || (bus.data_in < U_MIN);
    end

    always_ff @(posedge clock) begin
        if (reset)               bus.sat_flag <= 1'b0;
        else if (state == FINAL) bus.sat_flag <= sat_in | (y_rnd > OMAX) | (y_rnd < OMIN);
    end
`endif
endmodule
